// File: rtl/nonogram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nonogram_pkg: shared phase encoding and line word type.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package nonogram_pkg;

  localparam int LINE_W = 16;

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    RECEIVE  = 2'd0,
    SOLVE    = 2'd1,
    TRANSMIT = 2'd2,
    FLUSH    = 2'd3
  } phase_t;

endpackage
`default_nettype wire

// File: rtl/fifo_occ_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_occ_tracker: gates FIFO requests, tracks saturating occupancy   |
// | and raises sticky overflow/underflow flags.                          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fifo_occ_tracker #(
  parameter int FIFO_DEPTH = 512,
  parameter int OCC_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_wr_req,
  input  logic             i_rd_req,
  input  logic             i_full,
  input  logic             i_empty,
  output logic             o_wr_accept,
  output logic             o_rd_accept,
  output logic [OCC_W-1:0] o_occupancy,
  output logic             o_overflow_err,
  output logic             o_underflow_err
);

  localparam logic [OCC_W-1:0] c_occ_max = OCC_W'(FIFO_DEPTH);

  logic [OCC_W-1:0] r_occ;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_wr_accept;
  logic             w_rd_accept;

  assign w_wr_accept = i_wr_req & ~i_full;
  assign w_rd_accept = i_rd_req & ~i_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_wr_req && i_full)
        r_overflow <= 1'b1;
      if (i_rd_req && i_empty)
        r_underflow <= 1'b1;
      // A clear (phase exit) overrides any same-cycle traffic.
      if (i_clear)
        r_occ <= '0;
      else if (w_wr_accept && !w_rd_accept && (r_occ != c_occ_max))
        r_occ <= r_occ + 1'b1;
      else if (w_rd_accept && !w_wr_accept && (r_occ != '0))
        r_occ <= r_occ - 1'b1;
    end
  end

  assign o_wr_accept     = w_wr_accept;
  assign o_rd_accept     = w_rd_accept;
  assign o_occupancy     = r_occ;
  assign o_overflow_err  = r_overflow;
  assign o_underflow_err = r_underflow;

endmodule
`default_nettype wire

// File: rtl/nonogram_phase_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nonogram_phase_ctrl: RECEIVE->SOLVE->TRANSMIT->FLUSH sequencer and   |
// | line-FIFO arbiter. Optional SOLVE watchdog: PHASE_WATCHDOG_EN.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module nonogram_phase_ctrl
  import nonogram_pkg::*;
#(
  parameter  int LINE_W         = nonogram_pkg::LINE_W,
  parameter  int FIFO_DEPTH     = 512,
  parameter  int FLUSH_CYCLES   = 4,
  parameter  int TIMEOUT_CYCLES = 50_000_000,
  localparam int OCC_W          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              parsed,
  input  logic              parse_write,
  input  logic [LINE_W-1:0] parse_line,
  input  logic              solve_write,
  input  logic [LINE_W-1:0] solve_line,
  input  logic              solve_next,
  input  logic              solved,
  input  logic              unsolvable,
  input  logic              assembled,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  output logic              fifo_wr_en,
  output logic [LINE_W-1:0] fifo_din,
  output logic              fifo_rd_en,
  output logic              fifo_srst,
  output logic              solve_start,
  output logic              assemble_start,
  output logic [1:0]        phase,
  output logic [OCC_W-1:0]  occupancy,
  output logic              overflow_err,
  output logic              underflow_err,
  output logic              timeout
);

  localparam int                     c_flush_cnt_w = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [c_flush_cnt_w-1:0] c_flush_last = c_flush_cnt_w'(FLUSH_CYCLES - 1);

  phase_t                   r_phase;
  logic [c_flush_cnt_w-1:0] r_flush_cnt;
  logic                     r_fifo_srst;
  logic                     r_solve_start;
  logic                     r_assemble_start;

  logic                     w_wr_req;
  logic                     w_rd_req;
  logic                     w_solve_exit;
  logic                     w_wd_hit;

  // Write-port ownership follows the phase; TRANSMIT and FLUSH leave the FIFO idle.
  always_comb begin
    w_wr_req = 1'b0;
    w_rd_req = 1'b0;
    fifo_din = '0;
    case (r_phase)
      RECEIVE: begin
        w_wr_req = parse_write;
        fifo_din = parse_line;
      end
      SOLVE: begin
        w_wr_req = solve_write;
        w_rd_req = solve_next;
        fifo_din = solve_line;
      end
      default: ;
    endcase
  end

  assign w_solve_exit = (r_phase == SOLVE) && (solved || unsolvable || w_wd_hit);

  fifo_occ_tracker #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .OCC_W      (OCC_W)
  ) u_occ (
    .clk             (clk),
    .rst             (rst),
    .i_clear         (w_solve_exit),
    .i_wr_req        (w_wr_req),
    .i_rd_req        (w_rd_req),
    .i_full          (fifo_full),
    .i_empty         (fifo_empty),
    .o_wr_accept     (fifo_wr_en),
    .o_rd_accept     (fifo_rd_en),
    .o_occupancy     (occupancy),
    .o_overflow_err  (overflow_err),
    .o_underflow_err (underflow_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase          <= RECEIVE;
      r_flush_cnt      <= '0;
      r_fifo_srst      <= 1'b1;
      r_solve_start    <= 1'b0;
      r_assemble_start <= 1'b0;
    end else begin
      r_fifo_srst      <= 1'b0;
      r_solve_start    <= 1'b0;
      r_assemble_start <= 1'b0;
      case (r_phase)
        RECEIVE: begin
          if (parsed) begin
            r_phase       <= SOLVE;
            r_solve_start <= 1'b1;
          end
        end
        SOLVE: begin
          // Solver verdicts outrank the watchdog; unsolvable outranks solved.
          if (unsolvable || (!solved && w_wd_hit)) begin
            r_phase     <= FLUSH;
            r_flush_cnt <= '0;
            r_fifo_srst <= 1'b1;
          end else if (solved) begin
            r_phase          <= TRANSMIT;
            r_fifo_srst      <= 1'b1;
            r_assemble_start <= 1'b1;
          end
        end
        TRANSMIT: begin
          if (assembled) begin
            r_phase     <= FLUSH;
            r_flush_cnt <= '0;
            r_fifo_srst <= 1'b1;
          end
        end
        default: begin
          if (r_flush_cnt == c_flush_last) begin
            r_phase <= RECEIVE;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
            r_fifo_srst <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef PHASE_WATCHDOG_EN
  localparam int                  c_wd_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_wd_w-1:0]   c_wd_last = c_wd_w'(TIMEOUT_CYCLES - 1);

  logic [c_wd_w-1:0] r_wd_cnt;
  logic              r_timeout;

  assign w_wd_hit = (r_phase == SOLVE) && (r_wd_cnt == c_wd_last);

  // Counter idles at zero outside SOLVE so every SOLVE entry starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_phase != SOLVE)
        r_wd_cnt <= '0;
      else if (!w_wd_hit)
        r_wd_cnt <= r_wd_cnt + 1'b1;
      if (w_wd_hit && !solved && !unsolvable)
        r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign w_wd_hit             = 1'b0;
  assign timeout              = 1'b0;
`endif

  assign fifo_srst      = r_fifo_srst;
  assign solve_start    = r_solve_start;
  assign assemble_start = r_assemble_start;
  assign phase          = r_phase;

endmodule
`default_nettype wire
